// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction fetch path.
// Contents:
//   - icode values for every defined instruction class
//   - default instruction memory size and maximum instruction length
//   - fetch FSM state encoding (exported on the fetch unit's debug port)
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam int unsigned MEM_SIZE_DEFAULT  = 256;
  localparam int unsigned MAX_BYTES_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length decoder (purely combinational).
// Maps an icode to the total instruction length in bytes. Undefined icodes
// (C..F) report length 1 and raise invalid_o so the caller can stop after
// the first byte. Also used by the fetch stage's valP computation.
// Ports:
//   icode_i   [3:0]  icode, upper nibble of instruction byte 0
//   len_o     [3:0]  instruction length in bytes (1, 2, 9 or 10)
//   invalid_o        icode is not a defined instruction
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       invalid_o
);

  always_comb begin
    len_o     = 4'd1;
    invalid_o = 1'b0;
    case (icode_i)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                  len_o = 4'd1;
      ICODE_CMOVXX, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  len_o = 4'd2;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          len_o = 4'd10;
      ICODE_JXX, ICODE_CALL:                             len_o = 4'd9;
      default: begin
        len_o     = 4'd1;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory fetch unit.
// On an accepted start, reads the instruction at pc one byte at a time from
// a byte-wide memory, sizes the instruction from its first byte and presents
// the assembled instruction, its length and its PC with a one-cycle
// instr_valid pulse. Results hold until the next accepted start.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start, pc                fetch request and instruction address (IDLE only)
//   busy                     a fetch is in progress (REQ or DONE)
//   mem_req, mem_addr        byte read request and address
//   mem_ack, mem_rdata       byte read completion and data
//   instr                    assembled instruction, byte 0 in the top byte
//   instr_len                bytes fetched
//   pc_out                   PC of the instruction in instr
//   instr_valid              one-cycle pulse, outputs are final
//   mem_error                fetch ran past the end of memory
//   invalid_instr            byte 0 carries an undefined icode
//   state_o                  current FSM state (debug)
//
// Memory handshake: mem_req is high only in REQ with an in-range address,
// mem_addr is constant for as long as mem_req stays high, and a byte is
// transferred on every rising edge where mem_req and mem_ack are both high
// (mem_ack may already be high in the first request cycle). mem_ack is
// ignored whenever mem_req is low.
module imem_fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEFAULT,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [63:0]            pc,
  output logic                   busy,
  output logic                   mem_req,
  output logic [63:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic [8*MAX_BYTES-1:0] instr,
  output logic [3:0]             instr_len,
  output logic [63:0]            pc_out,
  output logic                   instr_valid,
  output logic                   mem_error,
  output logic                   invalid_instr,
  output logic [1:0]             state_o
);

  localparam int INSTR_W = 8 * MAX_BYTES;

  fetch_state_e         state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic [3:0]           len_tgt_q, len_tgt_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [3:0]           instr_len_q, instr_len_d;
  logic [63:0]          pc_out_q, pc_out_d;
  logic                 mem_error_q, mem_error_d;
  logic                 invalid_q, invalid_d;

  logic [3:0]           dec_len;
  logic                 dec_invalid;
  logic [3:0]           cur_len;
  logic [3:0]           k_next;
  logic [64:0]          tgt_addr;
  logic                 addr_bad;

  instr_len_decode u_len_decode (
    .icode_i   (mem_rdata[7:4]),
    .len_o     (dec_len),
    .invalid_o (dec_invalid)
  );

  // 65-bit sum so a PC near 2^64 that wraps is caught as out of range.
  assign tgt_addr = {1'b0, pc_out_q} + {61'b0, k_q};
  assign addr_bad = tgt_addr[64] || (tgt_addr > (65'(MEM_SIZE) - 65'd1));

  // The length is only known once byte 0 arrives; until then use the
  // decoder output directly.
  assign cur_len = (k_q == 4'd0) ? dec_len : len_tgt_q;
  assign k_next  = k_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_tgt_d   = len_tgt_q;
    instr_d     = instr_q;
    instr_len_d = instr_len_q;
    pc_out_d    = pc_out_q;
    mem_error_d = mem_error_q;
    invalid_d   = invalid_q;
    mem_req     = 1'b0;
    mem_addr    = 64'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_REQ;
          pc_out_d    = pc;
          instr_d     = '0;
          instr_len_d = 4'd0;
          mem_error_d = 1'b0;
          invalid_d   = 1'b0;
          k_d         = 4'd0;
          len_tgt_d   = 4'd0;
        end
      end

      ST_REQ: begin
        if (addr_bad) begin
          // Never issue a request outside memory; report what was fetched.
          mem_error_d = 1'b1;
          instr_len_d = k_q;
          state_d     = ST_DONE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = tgt_addr[63:0];
          if (mem_ack) begin
            for (int b = 0; b < MAX_BYTES; b++) begin
              if (k_q == 4'(b)) begin
                instr_d[INSTR_W-1-8*b -: 8] = mem_rdata;
              end
            end
            k_d = k_next;
            if (k_q == 4'd0) begin
              len_tgt_d = dec_len;
              invalid_d = dec_invalid;
            end
            if ((k_next == cur_len) || (k_next == 4'(MAX_BYTES))) begin
              instr_len_d = k_next;
              state_d     = ST_DONE;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 4'd0;
      len_tgt_q   <= 4'd0;
      instr_q     <= '0;
      instr_len_q <= 4'd0;
      pc_out_q    <= 64'd0;
      mem_error_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_tgt_q   <= len_tgt_d;
      instr_q     <= instr_d;
      instr_len_q <= instr_len_d;
      pc_out_q    <= pc_out_d;
      mem_error_q <= mem_error_d;
      invalid_q   <= invalid_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign instr_valid   = (state_q == ST_DONE);
  assign instr         = instr_q;
  assign instr_len     = instr_len_q;
  assign pc_out        = pc_out_q;
  assign mem_error     = mem_error_q;
  assign invalid_instr = invalid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;
  import y86_pkg::*;

  localparam int MEM_BYTES = 256;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] pc = 64'd0;
  logic        busy;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [79:0] instr;
  logic [3:0]  instr_len;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        mem_error;
  logic        invalid_instr;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  imem_fetch_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pc            (pc),
    .busy          (busy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_len     (instr_len),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .mem_error     (mem_error),
    .invalid_instr (invalid_instr),
    .state_o       (state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory model / responder ----------------
  logic [7:0]  mem [MEM_BYTES];
  int          wait_fixed = 0;   // -1: random 0..3 wait states per byte
  int          wait_cnt = 0;
  int          wait_tgt = 0;
  bit          stale_force = 1'b0;
  int          valid_pulses = 0;
  logic [63:0] act_q[$];

  function automatic int next_wait();
    return (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(3, 0));
  endfunction

  always @(negedge clk) begin
    if (instr_valid) valid_pulses++;
    if (stale_force) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hAA;
    end else if (mem_req) begin
      check_eq("req_addr_in_range", {79'b0, (mem_addr < 64'(MEM_BYTES))}, 80'd1);
      if (wait_cnt >= wait_tgt) begin
        mem_ack   = 1'b1;
        mem_rdata = (mem_addr < 64'(MEM_BYTES)) ? mem[mem_addr[7:0]] : 8'h00;
        act_q.push_back(mem_addr);
        wait_cnt  = 0;
        wait_tgt  = next_wait();
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // Length by icode, straight from the instruction set table.
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  logic [63:0] exp_q[$];

  task automatic model(input logic [63:0] p, output logic [79:0] e_instr,
                       output logic [3:0] e_len, output bit e_err, output bit e_inv);
    logic [64:0] a;
    logic [7:0]  byte_v;
    int          tgt;
    int          k;
    e_instr = '0;
    e_err   = 1'b0;
    e_inv   = 1'b0;
    tgt     = 10;
    k       = 0;
    exp_q.delete();
    while (k < tgt) begin
      a = {1'b0, p} + 65'(k);
      if (a > 65'(MEM_BYTES - 1)) begin
        e_err = 1'b1;
        break;
      end
      exp_q.push_back(a[63:0]);
      byte_v = mem[a[7:0]];
      e_instr[79-8*k -: 8] = byte_v;
      if (k == 0) begin
        tgt   = len_tab[byte_v[7:4]];
        e_inv = (byte_v[7:4] > 4'hB);
      end
      k++;
    end
    e_len = 4'(k);
  endtask

  // ---------------- driver ----------------
  task automatic run_fetch(input string name, input logic [63:0] p, input int wfix,
                           input bit poke, input logic [63:0] p2);
    logic [79:0] e_instr;
    logic [3:0]  e_len;
    bit          e_err, e_inv, got;
    int          cycles;
    model(p, e_instr, e_len, e_err, e_inv);
    act_q.delete();
    wait_fixed = wfix;
    @(posedge clk);
    #1;
    wait_cnt = 0;
    wait_tgt = next_wait();
    start = 1'b1;
    pc    = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    pc    = {$urandom, $urandom};
    cycles = 0;
    got    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check_eq({name, "_busy"}, {79'b0, busy}, 80'd1);
      if (cycles == 3) start = 1'b0;
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      if (poke && cycles == 2) begin
        start = 1'b1;
        pc    = p2;
      end
    end
    start = 1'b0;
    check_eq({name, "_valid_seen"}, {79'b0, got}, 80'd1);
    check_eq({name, "_instr"}, instr, e_instr);
    check_eq({name, "_len"}, {76'b0, instr_len}, {76'b0, e_len});
    check_eq({name, "_pc_out"}, {16'b0, pc_out}, {16'b0, p});
    check_eq({name, "_mem_error"}, {79'b0, mem_error}, {79'b0, e_err});
    check_eq({name, "_invalid"}, {79'b0, invalid_instr}, {79'b0, e_inv});
    if (wfix == 0)
      check_eq({name, "_latency"}, 80'(cycles), 80'(int'(e_len) + (e_err ? 2 : 1)));
    check_eq({name, "_nreq"}, 80'(act_q.size()), 80'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0)
      check_eq({name, "_req_addr"}, {16'b0, act_q.pop_front()}, {16'b0, exp_q.pop_front()});
    @(negedge clk);
    check_eq({name, "_valid_width"}, {79'b0, instr_valid}, 80'd0);
    check_eq({name, "_idle_busy"}, {79'b0, busy}, 80'd0);
    @(negedge clk);
    check_eq({name, "_hold_instr"}, instr, e_instr);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_state"}, {78'b0, state_o}, {78'b0, ST_IDLE});
    check_eq({name, "_busy"}, {79'b0, busy}, 80'd0);
    check_eq({name, "_req"}, {79'b0, mem_req}, 80'd0);
    check_eq({name, "_addr"}, {16'b0, mem_addr}, 80'd0);
    check_eq({name, "_instr"}, instr, 80'd0);
    check_eq({name, "_len"}, {76'b0, instr_len}, 80'd0);
    check_eq({name, "_pc_out"}, {16'b0, pc_out}, 80'd0);
    check_eq({name, "_valid"}, {79'b0, instr_valid}, 80'd0);
    check_eq({name, "_flags"}, {78'b0, mem_error, invalid_instr}, 80'd0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < MEM_BYTES; a++) mem[a] = 8'($urandom);
  endtask

  task automatic reset_mid_fetch();
    int v0;
    bit reached;
    fill_random();
    mem[8'h40] = 8'h40;  // rmmovq, 10 bytes
    wait_fixed = 0;
    @(posedge clk);
    #1;
    wait_cnt = 0;
    wait_tgt = 0;
    start = 1'b1;
    pc    = 64'h40;
    @(posedge clk);
    #1;
    start = 1'b0;
    act_q.delete();
    v0 = valid_pulses;
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (act_q.size() >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_three_bytes", {79'b0, reached}, 80'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale_force = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    stale_force = 1'b0;
    @(negedge clk);
    check_all_zero("rst_stale_ack");
    repeat (3) @(negedge clk);
    check_eq("rst_no_valid", 80'(valid_pulses - v0), 80'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rp;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // nop at 0, zero-wait
    mem[0] = 8'h10;
    run_fetch("nop", 64'h0, 0, 1'b0, 64'h0);

    // irmovq at 0x20, two wait states per byte
    mem[8'h20] = 8'h30; mem[8'h21] = 8'hF3; mem[8'h22] = 8'h0A;
    for (int a = 8'h23; a <= 8'h29; a++) mem[a] = 8'h00;
    run_fetch("irmovq", 64'h20, 2, 1'b0, 64'h0);
    check_eq("irmovq_top16", {64'b0, instr[79:64]}, 80'h30F3);
    check_eq("irmovq_byte2", {72'b0, instr[63:56]}, 80'h0A);

    // jxx running off the end of memory
    mem[8'hF8] = 8'h70;
    run_fetch("jxx_end", 64'hF8, 0, 1'b0, 64'h0);

    // undefined icode
    mem[8'h10] = 8'hD0;
    run_fetch("bad_icode", 64'h10, 0, 1'b0, 64'h0);

    // 10-byte instruction ending exactly at the last byte, and one byte later
    mem[8'hF6] = 8'h50;
    run_fetch("last_legal", 64'hF6, 0, 1'b0, 64'h0);
    mem[8'hF7] = 8'h30;
    run_fetch("one_past", 64'hF7, 0, 1'b0, 64'h0);

    // fully out of range and wrap-around PCs
    run_fetch("pc_256", 64'h100, 0, 1'b0, 64'h0);
    run_fetch("pc_max", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'h0);

    // halt is a plain 1-byte fetch
    mem[8'h33] = 8'h00;
    run_fetch("halt", 64'h33, 0, 1'b0, 64'h0);

    // reset in the middle of a fetch, then a clean fetch from 0
    reset_mid_fetch();
    mem[0] = 8'h61;
    run_fetch("after_rst", 64'h0, 0, 1'b0, 64'h0);

    // start while busy is ignored
    mem[8'h50] = 8'h80;
    mem[8'h90] = 8'h10;
    run_fetch("busy_poke", 64'h50, 1, 1'b1, 64'h90);

    // randomized fetches
    for (int n = 0; n < 40; n++) begin
      fill_random();
      case ($urandom_range(3, 0))
        0: rp = 64'($urandom_range(255, 0));
        1: rp = 64'($urandom_range(255, 240));
        2: rp = 64'($urandom_range(250, 244));
        default: rp = {$urandom, $urandom};
      endcase
      run_fetch("rand", rp, ($urandom_range(1, 0) == 0) ? 0 : -1,
                ($urandom_range(3, 0) == 0), {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Upstream neighbour of the fetch/decode stage.
- Given a PC and a start pulse, reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake.
- Determines instruction length from the first byte and assembles a 10-byte instruction bus `instr[0:79]` (memory byte k at bits `[8k:8k+7]`).
- Flags out-of-range addresses and undefined icodes.
- Output feeds the fetch stage's `instr` and `PC` inputs directly.

Parameters:
- MEM_SIZE, 256, instruction memory size in bytes; valid addresses are 0 to MEM_SIZE-1.
- MAX_BYTES, 10, maximum instruction length in bytes.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request a fetch at `pc`; accepted only when `busy`=0.
- pc  input  64  address of the instruction's first byte; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until `instr_valid` deasserts.
- mem_req  output  1  byte read request; held high until `mem_ack`.
- mem_addr  output  64  byte address; stable while `mem_req`=1.
- mem_ack  input  1  byte returned this cycle on `mem_rdata`; ignored when `mem_req`=0.
- mem_rdata  input  8  returned byte.
- instr  output  80  assembled instruction; byte 0 at bits [0:7]; unfetched bytes are 0.
- instr_len  output  4  bytes fetched (1, 2, 9 or 10; fewer on `mem_error`).
- pc_out  output  64  PC of the instruction in `instr`.
- instr_valid  output  1  one-cycle pulse: `instr`, `instr_len`, `pc_out`, error flags are final.
- mem_error  output  1  address exceeded MEM_SIZE-1 during this fetch.
- invalid_instr  output  1  icode of byte 0 > 4'hB.

Behaviour:
- Reset (`rst_n`=0 at edge): state IDLE; `mem_req`, `busy`, `instr_valid`, `mem_error`, `invalid_instr` = 0; `instr`, `instr_len`, `pc_out`, `mem_addr` = 0. Applies mid-fetch as well: the outstanding request is dropped and a later `mem_ack` is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `start`=1 → REQ.
  - Latch `pc` into `pc_out`; clear `instr`, `instr_len`, flags; set byte counter k=0.
- REQ, address check: before asserting `mem_req`, check the target address (`pc_out`+k, computed at 65 bits). If it is > MEM_SIZE-1, or carries out of 64 bits:
  - Set `mem_error`=1.
  - Do not issue the request; → DONE with `instr_len`=k.
- REQ, normal: `mem_req`=1, `mem_addr`=`pc_out`+k. On `mem_ack`:
  - Write `mem_rdata` to `instr[8k:8k+7]`; increment k.
  - When k=0, compute target length L from icode = `mem_rdata[7:4]`:
    - 0, 1, 9 → 1
    - 2, 6, A, B → 2
    - 3, 4, 5 → 10
    - 7, 8 → 9
    - C–F → 1, with `invalid_instr`=1
  - When k+1 = L: `instr_len`=L, → DONE. Otherwise stay in REQ with `mem_req` high and address advanced to the next byte.
- Back-to-back acks: with a zero-wait memory (`mem_ack` in the same cycle as `mem_req`), one byte is captured per cycle. Wait states simply hold REQ.
- DONE: `instr_valid`=1 for exactly one cycle, `mem_req`=0, then → IDLE.
- Latency: start accepted at edge t, zero-wait memory, L bytes → `instr_valid` high in the cycle after edge t+L.
- Output hold: `instr`, `instr_len`, `pc_out` and the flags hold their values after DONE until the next accepted start.
- `start` while `busy`: ignored; no queueing.
- Simultaneous errors: `invalid_instr` and `mem_error` are independent. A halt byte (icode 0) is a normal 1-byte fetch; halting is the downstream stage's job.
- Boundary: a 10-byte instruction at `pc`=MEM_SIZE-10 is legal (last byte at MEM_SIZE-1). At MEM_SIZE-9, `mem_error` is raised after 9 bytes.

Decomposition:
- Shared package `y86_pkg`:
  - icode localparams (HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ).
  - MEM_SIZE default.
  - FSM state enum.
- One combinational sub-module `instr_len_decode`: icode in → length (4 bits) and invalid flag out. It is reused by the fetch stage's valP logic.

Test Plan:
- Zero-wait memory, `pc`=0, mem[0]=8'h10 (nop), start → one request at addr 0; `instr_valid` one cycle after the ack edge; `instr`[0:7]=8'h10, rest 0; `instr_len`=1; no flags.
- `pc`=8'h20, mem[0x20..0x29]=30 F3 0A 00.. (irmovq), 2-cycle wait per ack → 10 requests at addresses 0x20–0x29 in order; `instr_len`=10; `instr`[0:15]=16'h30F3; [16:23]=8'h0A; `instr_valid` pulse width 1.
- `pc`=0xF8, mem[0xF8]=8'h70 (jxx, 9 bytes) → bytes 0xF8–0xFF fetched; no request at 0x100; `mem_error`=1; `instr_len`=8.
- `pc`=0x10, mem[0x10]=8'hD0 → `invalid_instr`=1; `instr_len`=1; exactly one request issued.
- Assert `rst_n`=0 for one edge mid-fetch (after 3 bytes of a rmmovq), then drive a stale `mem_ack` → all outputs 0, state IDLE, no `instr_valid`; a subsequent start at `pc`=0 fetches correctly.
- Pulse `start` again while `busy` with a different `pc` → ignored; `pc_out` and `instr` match the first request only.
